// File: rtl/inst_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module  : inst_axi_rd_bridge
// Brief   : IF-side sram-like fetch port to single-beat AXI4 reads, in order.
// Revision: 1.0  initial release
// ============================================================================
module inst_axi_rd_bridge #(
    parameter logic [3:0]  ARID_VAL = 4'd0,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } ar_state_e;

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUT);

    ar_state_e   ar_state_q, ar_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic w_accept;
    logic w_r_hs;
    logic w_dec;
    logic w_r_err;
    logic w_unused_ok;

    // Write data/strobes and the low address bits have no role in a word fetch.
    assign w_unused_ok = &{1'b0, inst_sram_wen, inst_sram_wdata, inst_sram_addr[1:0]};

    // No AXI input feeds addr_ok, so IF never sees a combinational path from arready.
    assign inst_sram_addr_ok = inst_sram_en & ~inst_sram_wr & (ar_state_q == ST_IDLE)
                             & (cnt_q < c_MAX_OUT);
    assign w_accept = inst_sram_addr_ok;
    assign w_r_hs   = rvalid;
    assign w_dec    = w_r_hs & rlast & (cnt_q != 4'd0);
    assign w_r_err  = w_r_hs & ((rresp != 2'b00) | (rid != ARID_VAL) | ~rlast | (cnt_q == 4'd0));

    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        arsize_d   = arsize_q;
        cnt_d      = cnt_q;
        data_ok_d  = w_r_hs;
        rdata_d    = rdata_q;
        bus_err_d  = bus_err_q | (inst_sram_en & inst_sram_wr) | w_r_err;

        case (ar_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    ar_state_d = ST_REQ;
                    araddr_d   = {inst_sram_addr[31:2], 2'b00};
                    arsize_d   = {1'b0, inst_sram_size};
                end
            end
            ST_REQ: begin
                if (arready) begin
                    ar_state_d = ST_IDLE;
                end
            end
            default: ar_state_d = ST_IDLE;
        endcase

        case ({w_accept, w_dec})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase

        if (w_r_hs) begin
            rdata_d = rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state_q <= ST_IDLE;
            araddr_q   <= 32'd0;
            arsize_q   <= 3'd0;
            cnt_q      <= 4'd0;
            data_ok_q  <= 1'b0;
            rdata_q    <= 32'd0;
            bus_err_q  <= 1'b0;
        end else begin
            ar_state_q <= ar_state_d;
            araddr_q   <= araddr_d;
            arsize_q   <= arsize_d;
            cnt_q      <= cnt_d;
            data_ok_q  <= data_ok_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign arvalid           = (ar_state_q == ST_REQ);
    assign araddr            = araddr_q;
    assign arsize            = arsize_q;
    assign arid              = ARID_VAL;
    assign arlen             = 8'd0;
    assign arburst           = 2'b01;
    assign arlock            = 2'b00;
    assign arcache           = 4'd0;
    assign arprot            = 3'd0;
    assign rready            = 1'b1;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
    assign bus_err           = bus_err_q;

endmodule
`default_nettype wire

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Upstream neighbour of the IF stage: the slave end of IF's inst sram-like port (en/addr_ok/data_ok).
- Converts each accepted instruction fetch into a single-beat AXI4 read, with up to MAX_OUT reads outstanding.
- Returns fetched words to IF in strict request order as one-cycle data_ok pulses.
- Sits between if_stage and the CPU-top AXI read arbiter.

Parameters:
- ARID_VAL, 4'd0, constant driven on arid and expected on rid.
- MAX_OUT, 2, maximum accepted-but-unreturned reads; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_sram_en  in  1  IF request valid.
- inst_sram_wr  in  1  must be 0; write requests are never accepted.
- inst_sram_size  in  2  request size, copied to arsize.
- inst_sram_wen  in  4  ignored.
- inst_sram_addr  in  32  fetch address.
- inst_sram_wdata  in  32  ignored.
- inst_sram_addr_ok  out  1  request accepted this cycle.
- inst_sram_data_ok  out  1  one-cycle pulse: inst_sram_rdata valid.
- inst_sram_rdata  out  32  returned instruction word.
- arid  out  4  = ARID_VAL.
- araddr  out  32  read address, word-aligned.
- arlen  out  8  = 0.
- arsize  out  3  = {1'b0, latched size}.
- arburst  out  2  = 2'b01.
- arlock  out  2  = 0.
- arcache  out  4  = 0.
- arprot  out  3  = 0.
- arvalid  out  1  AR request valid.
- arready  in  1  AR accept.
- rid  in  4  response id.
- rdata  in  32  response data.
- rresp  in  2  response status.
- rlast  in  1  last beat.
- rvalid  in  1  response valid.
- rready  out  1  response accept.
- bus_err  out  1  sticky error flag.

Behaviour:
- Reset (resetn=0, asynchronous): arvalid=0, araddr=0, arsize=0, inst_sram_data_ok=0, inst_sram_rdata=0, bus_err=0, outstanding count cnt=0. Held until resetn rises.
- addr_ok (combinational) = inst_sram_en & ~inst_sram_wr & ~arvalid & (cnt < MAX_OUT). Depends on no AXI input, so there is no same-cycle loop through arready.
- A write request (en=1, wr=1) is never acknowledged and sets bus_err.
- Accept cycle (en & addr_ok):
  - next edge: arvalid<=1, araddr<={inst_sram_addr[31:2],2'b00}, arsize<={1'b0,inst_sram_size}.
  - araddr and arsize stay stable while arvalid=1.
  - arvalid clears on the edge where arvalid & arready.
- AR FSM states: IDLE (arvalid=0) -> REQ on accept; REQ -> IDLE on arready.
  - No back-to-back: after arready, the next addr_ok is possible in the following cycle. Maximum throughput is one AR every 2 cycles.
- rready is tied to 1; R is never back-pressured.
- R handshake (rvalid & rready):
  - next edge: inst_sram_data_ok<=1 for exactly one cycle; inst_sram_rdata<=rdata (held until the next response).
  - Latency: data_ok is 1 cycle after the R beat; minimum accept-to-data_ok is 3 cycles.
- cnt:
  - +1 on accept; -1 on R handshake with rlast.
  - Both in the same cycle: unchanged.
  - cnt never exceeds MAX_OUT. An R beat while cnt=0 is a protocol violation: set bus_err, do not decrement.
- Ordering: all reads share ARID_VAL, so responses arrive and are returned in request order. No reordering buffer.
- bus_err is set (sticky until reset) by any of:
  - rresp!=0 on a handshake; data_ok is still pulsed with the returned data;
  - rid!=ARID_VAL on a handshake;
  - rvalid & ~rlast;
  - write request;
  - R beat with cnt=0.
- Mid-operation reset clears all state immediately. In-flight AXI responses are not tracked across reset; the system reset covers the interconnect.

Test Plan:
- Single fetch: en=1, addr=0xbfc00000, arready 1 cycle after arvalid, rvalid 2 cycles later with rdata=0x3c1a8000 -> addr_ok 1 cycle; araddr=0xbfc00000, arsize=3'b010; data_ok pulses once with rdata=0x3c1a8000; cnt returns to 0.
- Outstanding limit, MAX_OUT=2: en held high, arready=1, rvalid withheld -> exactly 2 addr_ok pulses (addresses 0xbfc00000, 0xbfc00004). Third request stalls until the first R beat, then is accepted.
- Order and back-to-back responses: two reads outstanding, R beats on consecutive cycles with 0x11111111 then 0x22222222 -> data_ok high for 2 consecutive cycles, rdata in that order.
- Simultaneous accept and response with cnt=1 -> cnt stays 1; araddr latches the new address; data_ok fires next cycle.
- Errors: rresp=2'b10 on a beat -> data_ok still pulses and bus_err=1 persists. en=1 with wr=1 -> no addr_ok, bus_err=1.
- Async reset: assert resetn=0 while arvalid=1 and cnt=1, mid-cycle -> arvalid, data_ok, bus_err and cnt are 0 immediately without a clock edge. After release, a fresh fetch behaves as in the single-fetch scenario.
